// File: rtl/onehot_decode_pipe.sv
// rtl/onehot_decode_pipe.sv - two-stage binary-to-one-hot decoder with valid/ready handshakes and saturating word counter
// Optional parity check over {in_en, in_code, in_parity} is enabled with `define DECODE_PARITY_EN.
module onehot_decode_pipe #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 8,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_code,
    input  logic             in_en,
`ifdef DECODE_PARITY_EN
    input  logic             in_parity,
    output logic             out_perr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [SEL_W-1:0] out_code,
    output logic [CNT_W-1:0] decode_cnt,
    output logic             cnt_sat
);

    localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [SEL_W-1:0] s1_code;
    logic             s1_en;
`ifdef DECODE_PARITY_EN
    logic             s1_parity;
`endif
    logic             s2_valid;
    logic             s2_en;

    logic             s2_move;
    logic             s1_take;
    logic             out_fire;
    logic             cnt_inc;
    logic             dec_perr;
    logic [OUT_W-1:0] dec_onehot;

    assign s2_move   = s1_valid && (!s2_valid || out_ready);
    assign s1_take   = !s1_valid || s2_move;
    assign in_ready  = s1_take && !rst;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;
    // A word counts only if it was enabled, parity-clean, and actually produced a hot bit.
    assign cnt_inc   = out_fire && s2_en && (out_onehot != '0);

    always_comb begin
`ifdef DECODE_PARITY_EN
        dec_perr = ^{s1_en, s1_code, s1_parity};
`else
        dec_perr = 1'b0;
`endif
        dec_onehot = '0;
        case ({s1_en, dec_perr})
            2'b10:   dec_onehot = ONE << s1_code;
            default: dec_onehot = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_en    <= 1'b0;
`ifdef DECODE_PARITY_EN
            s1_parity <= 1'b0;
`endif
        end else if (s1_take) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code  <= in_code;
                s1_en    <= in_en;
`ifdef DECODE_PARITY_EN
                s1_parity <= in_parity;
`endif
            end
        end
    end

    // Stage 2 data only changes when a new word moves in, so it holds steady under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_en      <= 1'b0;
            out_onehot <= '0;
            out_code   <= '0;
`ifdef DECODE_PARITY_EN
            out_perr   <= 1'b0;
`endif
        end else if (s2_move) begin
            s2_valid   <= 1'b1;
            s2_en      <= s1_en && !dec_perr;
            out_onehot <= dec_onehot;
            out_code   <= s1_code;
`ifdef DECODE_PARITY_EN
            out_perr   <= dec_perr;
`endif
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decode_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else if (cnt_inc && (decode_cnt != CNT_MAX)) begin
            decode_cnt <= decode_cnt + 1'b1;
            if (decode_cnt == CNT_MAX - 1'b1) begin
                cnt_sat <= 1'b1;
            end
        end
    end

endmodule
